data_mem: RTL

Word-organised synchronous data memory sitting directly downstream of the MEM stage. It consumes the MEM stage's memory request signals: read/write addresses, write data and enables. It returns load data one cycle later through a registered read port. Stores go through a one-entry posted-write buffer with store-to-load bypass, and misaligned accesses are trapped into a sticky error flag.

---
 rtl/data_mem.sv | 83 ++++++++
 1 files changed

// File: rtl/data_mem.sv
// Word-organised data memory behind the MEM stage with a one-entry posted-write buffer and store-to-load bypass.
// Latency: loads return registered data exactly 1 cycle after issue; stores become visible to the next cycle's load.
// Backpressure: none, a request is accepted every cycle and back-to-back stores never stall.
module data_mem #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_mem_read_enable,
    input  logic        data_mem_write_enable,
    input  logic [31:0] data_mem_read_addr,
    input  logic [31:0] data_mem_write_addr,
    input  logic [31:0] data_mem_write_data,
    output logic [31:0] data_mem_read_data,
    output logic        data_mem_read_valid,
    output logic        data_mem_misaligned
);

    logic [31:0]       mem [DEPTH_WORDS];

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_idx;
    logic [31:0]       wb_data;

    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              rd_aligned;
    logic              wr_aligned;
    logic              is_store;
    logic              is_load;
    logic              store_ok;
    logic              load_ok;
    logic              bypass_hit;

    // Upper address bits are dropped on purpose so accesses wrap modulo the array size.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{data_mem_read_addr[31:ADDR_W+2], data_mem_write_addr[31:ADDR_W+2]};

    assign rd_idx     = data_mem_read_addr[ADDR_W+1:2];
    assign wr_idx     = data_mem_write_addr[ADDR_W+1:2];
    assign rd_aligned = (data_mem_read_addr[1:0] == 2'b00);
    assign wr_aligned = (data_mem_write_addr[1:0] == 2'b00);

    assign is_store   = data_mem_write_enable;
    assign is_load    = data_mem_read_enable && !data_mem_write_enable;
    assign store_ok   = is_store && wr_aligned;
    assign load_ok    = is_load && rd_aligned;
    assign bypass_hit = wb_valid && (wb_idx == rd_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid            <= 1'b0;
            data_mem_read_data  <= 32'd0;
            data_mem_read_valid <= 1'b0;
            data_mem_misaligned <= 1'b0;
        end else begin
            wb_valid            <= store_ok;
            data_mem_read_valid <= load_ok;
            if (load_ok) begin
                data_mem_read_data <= bypass_hit ? wb_data : mem[rd_idx];
            end
            if ((is_store && !wr_aligned) || (is_load && !rd_aligned)) begin
                data_mem_misaligned <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_ok) begin
            wb_idx  <= wr_idx;
            wb_data <= data_mem_write_data;
        end
    end

    // Reset discards a buffered store rather than committing it.
    always_ff @(posedge clk) begin
        if (wb_valid && !rst) begin
            mem[wb_idx] <= wb_data;
        end
    end

endmodule
